sdram_read: RTL and testbench
=============================

# sdram_read

SDRAM read-burst sequencer: the read-side client of the SDRAM arbiter, the counterpart of the write module on the shared `rd_*` interconnect. On arbiter grant it:
- opens the target row,
- issues a full-page READ,
- captures `rd_burst_len` 16-bit words from the DQ bus after CAS latency,
- terminates the burst, precharges and signals completion.

Captured words go to the read FIFO.

## Interface
Parameters:
- `TRCD_CLK`, 2: ACTIVE→READ spacing in clocks (≥1)
- `TRP_CLK`, 2: PRECHARGE→next-command spacing in clocks (≥1)
- `CAS_LAT`, 3: CAS latency in clocks (2 or 3)

Ports:
- `sys_clk`  in  1  system clock. One clock; everything on the rising edge.
- `sys_rst_n`  in  1  asynchronous, active-low reset.
- `init_end`  in  1  SDRAM initialisation complete. Requests are ignored while low.
- `rd_en`  in  1  arbiter grant. Sampled only in IDLE.
- `rd_addr_in`  in  24  {bank[23:22], row[21:9], col[8:0]}. Latched at grant.
- `rd_burst_len`  in  10  words to read, 1..512. 0 is treated as 1; values >512 clamp to 512. Latched at grant.
- `sdram_data_in`  in  16  SDRAM DQ as seen by the controller.
- `rd_cmd`  out  4  {cs_n,ras_n,cas_n,we_n}: NOP 0111, ACTIVE 0011, READ 0101, BURST_STOP 0110, PRECHARGE 0010.
- `rd_ba`  out  2  bank address.
- `rd_addr`  out  13  row (ACTIVE), {4'b0000,col} (READ, A10=0), 13'h0400 (PRECHARGE, A10=1 all banks), 13'h1fff otherwise.
- `rd_end`  out  1  one-cycle pulse: sequence complete.
- `rd_sdram_data`  out  16  registered captured word.
- `rd_sdram_valid`  out  1  `rd_sdram_data` valid (read-FIFO write enable).

## Operation
- All outputs registered.
- Reset values:
  - `rd_cmd`=0111, `rd_ba`=2'b11, `rd_addr`=13'h1fff
  - `rd_end`=0, `rd_sdram_data`=0, `rd_sdram_valid`=0
  - state=IDLE, counters=0
- States:
  - IDLE → ACTIVE when `init_end && rd_en`; latch address and burst length.
  - ACTIVE, 1 cycle: cmd ACTIVE, `rd_ba`=bank, `rd_addr`=row.
  - TRCD, `TRCD_CLK-1` cycles NOP (skipped if `TRCD_CLK`=1).
  - READ, 1 cycle: cmd READ, bank, column.
  - RD_DATA, `CAS_LAT+BL-1` cycles. Counter `cnt` starts at 0 on the first RD_DATA cycle. BURST_STOP is issued in the cycle where `cnt==BL-1`; all other RD_DATA cycles are NOP.
  - PRE, 1 cycle: cmd PRECHARGE, `rd_addr`=13'h0400.
  - TRP, `TRP_CLK-1` cycles NOP.
  - END, 1 cycle: `rd_end`=1, NOP → IDLE.
- Capture: `sdram_data_in` is sampled at cycles t0+CAS_LAT+k, k=0..BL-1, where t0 is the READ cycle. It appears on `rd_sdram_data` with `rd_sdram_valid`=1 one cycle later. Outside that window valid=0 and data holds its last value.
- `rd_en` or `init_end` changing after grant is ignored: the sequence always completes (the arbiter holds the grant until `rd_end`).
- `rd_addr_in` and `rd_burst_len` changing mid-sequence have no effect.
- Column wrap past 511 is handled by SDRAM full-page mode. The block does not modify the column.
- Reset asserted mid-sequence: immediately forces all outputs and state to reset values. No PRECHARGE is issued, and there is no `rd_end`.

## Timing
Grant sampled at edge 0 (`rd_en=1` in IDLE). Cycle numbers below are for the defaults.
- ACTIVE is driven in cycle 1.
- READ in cycle 1+TRCD_CLK (3).
- Valid data in cycles t0+CAS_LAT+1 .. t0+CAS_LAT+BL.
- BURST_STOP in cycle t0+BL.
- PRECHARGE in cycle t0+CAS_LAT+BL.
- `rd_end` in cycle t0+CAS_LAT+BL+TRP_CLK.
- The next grant can be accepted at the edge ending the IDLE cycle after END.
- Total grant-to-`rd_end` = 1+TRCD_CLK+CAS_LAT+BL+TRP_CLK cycles (12 for BL=4).
- BL=1: BURST_STOP immediately follows READ (t0+1). Exactly one valid word.

## Test plan
- **Basic burst.** Reset, `init_end`=1, `rd_en`=1 at cycle 0, `rd_addr_in`={2'd1,13'h0123,9'h010}, BL=4; model drives DQ=16'hA000+k at cycles 6..9. Expect:
  - ACTIVE ba=1 addr=0x0123 at cycle 1
  - READ addr=0x0010 at 3
  - BURST_STOP at 7
  - valid with A000..A003 at 7..10
  - PRECHARGE addr=0x0400 at 10
  - `rd_end` at 12, NOP elsewhere
- **BL=1 and BL=0.** Expect READ at 3, BURST_STOP at 4, exactly one valid word at 7, `rd_end` at 9.
- **BL=512 full page.** Expect 512 consecutive valid cycles, BURST_STOP at t0+512, and `rd_end` 520 cycles after grant (defaults). BL=1023 behaves identically.
- **Gating.** `init_end`=0 with `rd_en`=1 for 20 cycles: `rd_cmd` stays 0111 and there is no `rd_end`. Raising `init_end` starts the sequence with ACTIVE in the next cycle.
- **Reset mid-burst.** Assert `sys_rst_n`=0 at cycle 8 of a BL=4 read. Expect all outputs at reset values asynchronously, no PRECHARGE, no `rd_end`. A new grant after release runs a clean sequence.
- **Back-to-back and parameter sweep.** Hold `rd_en` high with different addresses: second ACTIVE one cycle after the first IDLE following `rd_end`, using the new bank/row. Repeat with TRCD_CLK=1, TRP_CLK=1, CAS_LAT=2: data window shifts to t0+3..t0+2+BL.

Source files
------------

// File: rtl/sdram_read_if.sv
// sdram_read_if: bus between the SDRAM arbiter/controller and the read-burst
// sequencer.
//   master : arbiter side. Drives the grant, address, burst length and DQ.
//            Receives the command, bank, address, completion and captured data.
//   slave  : sdram_read side, with the opposite directions.
interface sdram_read_if;
  logic        init_end;
  logic        rd_en;
  logic [23:0] rd_addr_in;
  logic [9:0]  rd_burst_len;
  logic [15:0] sdram_data_in;
  logic [3:0]  rd_cmd;
  logic [1:0]  rd_ba;
  logic [12:0] rd_addr;
  logic        rd_end;
  logic [15:0] rd_sdram_data;
  logic        rd_sdram_valid;

  modport master (
    output init_end, rd_en, rd_addr_in, rd_burst_len, sdram_data_in,
    input  rd_cmd, rd_ba, rd_addr, rd_end, rd_sdram_data, rd_sdram_valid
  );

  modport slave (
    input  init_end, rd_en, rd_addr_in, rd_burst_len, sdram_data_in,
    output rd_cmd, rd_ba, rd_addr, rd_end, rd_sdram_data, rd_sdram_valid
  );
endinterface

// File: rtl/sdram_read.sv
// sdram_read: SDRAM read-burst sequencer.
// On a grant it runs ACTIVE -> (tRCD) -> full-page READ -> captures the burst
// after CAS latency -> BURST_STOP -> PRECHARGE all -> (tRP) -> rd_end pulse.
// Ports:
//   sys_clk    system clock, rising edge
//   sys_rst_n  asynchronous active-low reset
//   bus        sdram_read_if.slave:
//                grant/addr/len/DQ in; cmd/ba/addr/end/data/valid out
// All outputs are registered.
module sdram_read #(
  parameter int unsigned TRCD_CLK = 2,
  parameter int unsigned TRP_CLK  = 2,
  parameter int unsigned CAS_LAT  = 3
) (
  input  logic         sys_clk,
  input  logic         sys_rst_n,
  sdram_read_if.slave  bus
);

  typedef enum logic [2:0] {
    S_IDLE, S_ACTIVE, S_TRCD, S_READ, S_RD_DATA, S_PRE, S_TRP, S_END
  } state_t;

  localparam logic [3:0] CMD_NOP   = 4'b0111;
  localparam logic [3:0] CMD_ACT   = 4'b0011;
  localparam logic [3:0] CMD_READ  = 4'b0101;
  localparam logic [3:0] CMD_STOP  = 4'b0110;
  localparam logic [3:0] CMD_PRE   = 4'b0010;

  localparam logic [9:0] CAS_W     = 10'(CAS_LAT);
  localparam logic [9:0] TRCD_LAST = 10'(TRCD_CLK - 2);
  localparam logic [9:0] TRP_LAST  = 10'(TRP_CLK - 2);

  state_t      state_q;
  logic [9:0]  cnt_q;
  logic [1:0]  bank_q;
  logic [12:0] row_q;
  logic [8:0]  col_q;
  logic [9:0]  bl_q;
  logic [9:0]  bl_d;
  logic [9:0]  rd_last;

  logic [3:0]  rd_cmd_q;
  logic [1:0]  rd_ba_q;
  logic [12:0] rd_addr_q;
  logic        rd_end_q;
  logic [15:0] rd_data_q;
  logic        rd_valid_q;

  // Burst length 0 means 1; anything beyond a full page clamps to 512.
  always_comb begin
    bl_d = bus.rd_burst_len;
    if (bus.rd_burst_len == 10'd0)
      bl_d = 10'd1;
    else if (bus.rd_burst_len > 10'd512)
      bl_d = 10'd512;
  end

  // Last RD_DATA cycle index: the data window ends CAS_LAT+BL-1 cycles after READ.
  assign rd_last = bl_q + CAS_W - 10'd2;

  // Outputs are loaded on the same edge that enters the state they belong to,
  // so each command appears in the cycle its state occupies.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      bank_q     <= '0;
      row_q      <= '0;
      col_q      <= '0;
      bl_q       <= '0;
      rd_cmd_q   <= CMD_NOP;
      rd_ba_q    <= '1;
      rd_addr_q  <= '1;
      rd_end_q   <= 1'b0;
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      rd_cmd_q   <= CMD_NOP;
      rd_ba_q    <= '1;
      rd_addr_q  <= '1;
      rd_end_q   <= 1'b0;
      rd_valid_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (bus.init_end && bus.rd_en) begin
            bank_q    <= bus.rd_addr_in[23:22];
            row_q     <= bus.rd_addr_in[21:9];
            col_q     <= bus.rd_addr_in[8:0];
            bl_q      <= bl_d;
            state_q   <= S_ACTIVE;
            rd_cmd_q  <= CMD_ACT;
            rd_ba_q   <= bus.rd_addr_in[23:22];
            rd_addr_q <= bus.rd_addr_in[21:9];
          end
        end
        S_ACTIVE: begin
          if (TRCD_CLK == 1) begin
            state_q   <= S_READ;
            rd_cmd_q  <= CMD_READ;
            rd_ba_q   <= bank_q;
            rd_addr_q <= {4'b0000, col_q};
          end else begin
            state_q <= S_TRCD;
            cnt_q   <= '0;
          end
        end
        S_TRCD: begin
          if (cnt_q == TRCD_LAST) begin
            state_q   <= S_READ;
            rd_cmd_q  <= CMD_READ;
            rd_ba_q   <= bank_q;
            rd_addr_q <= {4'b0000, col_q};
          end else begin
            cnt_q <= cnt_q + 10'd1;
          end
        end
        S_READ: begin
          state_q <= S_RD_DATA;
          cnt_q   <= '0;
          if (bl_q == 10'd1)
            rd_cmd_q <= CMD_STOP;
        end
        S_RD_DATA: begin
          if (cnt_q >= CAS_W - 10'd1) begin
            rd_data_q  <= bus.sdram_data_in;
            rd_valid_q <= 1'b1;
          end
          if (cnt_q == rd_last) begin
            state_q   <= S_PRE;
            rd_cmd_q  <= CMD_PRE;
            rd_addr_q <= 13'h0400;
          end else begin
            cnt_q <= cnt_q + 10'd1;
            // Stop lands on the cycle where the incremented count hits BL-1.
            if (cnt_q + 10'd2 == bl_q)
              rd_cmd_q <= CMD_STOP;
          end
        end
        S_PRE: begin
          if (TRP_CLK == 1) begin
            state_q  <= S_END;
            rd_end_q <= 1'b1;
          end else begin
            state_q <= S_TRP;
            cnt_q   <= '0;
          end
        end
        S_TRP: begin
          if (cnt_q == TRP_LAST) begin
            state_q  <= S_END;
            rd_end_q <= 1'b1;
          end else begin
            cnt_q <= cnt_q + 10'd1;
          end
        end
        S_END: begin
          state_q <= S_IDLE;
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.rd_cmd         = rd_cmd_q;
  assign bus.rd_ba          = rd_ba_q;
  assign bus.rd_addr        = rd_addr_q;
  assign bus.rd_end         = rd_end_q;
  assign bus.rd_sdram_data  = rd_data_q;
  assign bus.rd_sdram_valid = rd_valid_q;

endmodule

// File: tb/tb_sdram_read.sv
// tb_sdram_read: drives two sdram_read instances (default timing, and
// TRCD=1/TRP=1/CAS=2) with identical stimulus and checks every output in every
// cycle against a timeline model derived from the grant cycle.
module tb_sdram_read;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        init_end_v;
  logic        rd_en_v;
  logic [23:0] addr_v;
  logic [9:0]  len_v;
  logic [15:0] dq_v;

  sdram_read_if ifa ();
  sdram_read_if ifb ();

  assign ifa.init_end = init_end_v;      assign ifb.init_end = init_end_v;
  assign ifa.rd_en = rd_en_v;            assign ifb.rd_en = rd_en_v;
  assign ifa.rd_addr_in = addr_v;        assign ifb.rd_addr_in = addr_v;
  assign ifa.rd_burst_len = len_v;       assign ifb.rd_burst_len = len_v;
  assign ifa.sdram_data_in = dq_v;       assign ifb.sdram_data_in = dq_v;

  sdram_read #(.TRCD_CLK(2), .TRP_CLK(2), .CAS_LAT(3)) dut_a (
    .sys_clk(clk), .sys_rst_n(rst_n), .bus(ifa.slave));
  sdram_read #(.TRCD_CLK(1), .TRP_CLK(1), .CAS_LAT(2)) dut_b (
    .sys_clk(clk), .sys_rst_n(rst_n), .bus(ifb.slave));

  logic [3:0]  cmd_o  [2];
  logic [1:0]  ba_o   [2];
  logic [12:0] addr_o [2];
  logic        end_o  [2];
  logic [15:0] data_o [2];
  logic        val_o  [2];

  assign cmd_o[0] = ifa.rd_cmd;          assign cmd_o[1] = ifb.rd_cmd;
  assign ba_o[0] = ifa.rd_ba;            assign ba_o[1] = ifb.rd_ba;
  assign addr_o[0] = ifa.rd_addr;        assign addr_o[1] = ifb.rd_addr;
  assign end_o[0] = ifa.rd_end;          assign end_o[1] = ifb.rd_end;
  assign data_o[0] = ifa.rd_sdram_data;  assign data_o[1] = ifb.rd_sdram_data;
  assign val_o[0] = ifa.rd_sdram_valid;  assign val_o[1] = ifb.rd_sdram_valid;

  // Reference model: per instance, the grant cycle and latched request.
  int          trcd_m [2] = '{2, 1};
  int          trp_m  [2] = '{2, 1};
  int          cas_m  [2] = '{3, 2};
  int          g_m    [2];
  int          idle_m [2];
  int          bl_m   [2];
  logic [1:0]  bank_m [2];
  logic [12:0] row_m  [2];
  logic [8:0]  col_m  [2];
  logic [15:0] last_m [2];
  logic [15:0] dq_hist [0:4095];
  int          c;
  int          total;
  int          bad;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s cycle=%0d observed=%h expected=%h", tag, c, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      g_m[d]    = -100000;
      idle_m[d] = 0;
      last_m[d] = '0;
    end
  endtask

  // Grant decision at the edge ending cycle c, using that cycle's inputs.
  task automatic model_edge();
    if (rst_n && init_end_v && rd_en_v) begin
      for (int d = 0; d < 2; d++) begin
        if (c >= idle_m[d]) begin
          g_m[d]    = c;
          bl_m[d]   = (len_v == 10'd0) ? 1 : (len_v > 10'd512) ? 512 : int'(len_v);
          bank_m[d] = addr_v[23:22];
          row_m[d]  = addr_v[21:9];
          col_m[d]  = addr_v[8:0];
          idle_m[d] = c + 1 + trcd_m[d] + cas_m[d] + bl_m[d] + trp_m[d] + 1;
        end
      end
    end
  endtask

  task automatic check_cycle();
    for (int d = 0; d < 2; d++) begin
      int r, t0, tot;
      logic [3:0]  ec;
      logic [12:0] ea;
      logic [15:0] ed;
      bit          ev, ee;
      string       p;
      p   = (d == 0) ? "A" : "B";
      r   = c - g_m[d];
      t0  = 1 + trcd_m[d];
      tot = t0 + cas_m[d] + bl_m[d] + trp_m[d];
      ec  = 4'b0111;
      ea  = 13'h1fff;
      ev  = 1'b0;
      ee  = 1'b0;
      if (r >= 1 && r <= tot) begin
        if (r == 1) begin
          ec = 4'b0011; ea = row_m[d];
          chk({p, ".ba_act"}, 16'(ba_o[d]), 16'(bank_m[d]));
        end else if (r == t0) begin
          ec = 4'b0101; ea = {4'b0000, col_m[d]};
          chk({p, ".ba_read"}, 16'(ba_o[d]), 16'(bank_m[d]));
        end else if (r == t0 + bl_m[d]) begin
          ec = 4'b0110;
        end else if (r == t0 + cas_m[d] + bl_m[d]) begin
          ec = 4'b0010; ea = 13'h0400;
        end
        ee = (r == tot);
        ev = (r >= t0 + cas_m[d] + 1) && (r <= t0 + cas_m[d] + bl_m[d]);
      end
      if (ev) last_m[d] = dq_hist[c - 1];
      ed = last_m[d];
      chk({p, ".cmd"},   16'(cmd_o[d]),  16'(ec));
      chk({p, ".addr"},  16'(addr_o[d]), 16'(ea));
      chk({p, ".end"},   16'(end_o[d]),  16'(ee));
      chk({p, ".valid"}, 16'(val_o[d]),  16'(ev));
      chk({p, ".data"},  data_o[d],      ed);
    end
  endtask

  // Inputs currently applied belong to cycle c; advance into cycle c+1.
  task automatic cycle();
    model_edge();
    @(negedge clk);
    c++;
    check_cycle();
    dq_v = 16'($urandom);
    dq_hist[c] = dq_v;
  endtask

  task automatic idle(input int n);
    repeat (n) cycle();
  endtask

  task automatic grant(input logic [23:0] a, input logic [9:0] l);
    init_end_v = 1'b1;
    rd_en_v    = 1'b1;
    addr_v     = a;
    len_v      = l;
    cycle();
    // Post-grant input changes must not affect the running sequence.
    rd_en_v = 1'b0;
    addr_v  = 24'($urandom);
    len_v   = 10'($urandom);
  endtask

  initial begin
    total = 0;
    bad   = 0;
    c     = 0;
    rst_n = 1'b0;
    init_end_v = 1'b0;
    rd_en_v    = 1'b0;
    addr_v     = '0;
    len_v      = '0;
    dq_v       = '0;
    dq_hist[0] = '0;
    model_reset();
    idle(3);
    rst_n = 1'b1;
    idle(2);

    // Basic burst
    grant({2'd1, 13'h0123, 9'h010}, 10'd4);
    idle(14);

    // BL=1 and BL=0
    grant(24'($urandom), 10'd1);
    idle(12);
    grant(24'($urandom), 10'd0);
    idle(12);

    // Gating by init_end
    init_end_v = 1'b0;
    rd_en_v    = 1'b1;
    addr_v     = 24'($urandom);
    len_v      = 10'd3;
    idle(20);
    grant(24'($urandom), 10'd3);
    idle(16);

    // Reset mid-burst at cycle 8 of a BL=4 read
    grant(24'($urandom), 10'd4);
    idle(7);
    rst_n = 1'b0;
    #1;
    for (int d = 0; d < 2; d++) begin
      chk("rst.cmd",   16'(cmd_o[d]),  16'h0007);
      chk("rst.ba",    16'(ba_o[d]),   16'h0003);
      chk("rst.addr",  16'(addr_o[d]), 16'h1fff);
      chk("rst.end",   16'(end_o[d]),  16'h0000);
      chk("rst.valid", 16'(val_o[d]),  16'h0000);
      chk("rst.data",  data_o[d],      16'h0000);
    end
    model_reset();
    rd_en_v    = 1'b1;
    init_end_v = 1'b1;
    idle(4);
    rst_n = 1'b1;
    grant(24'($urandom), 10'd4);
    idle(16);

    // Full page, and clamp from 1023
    grant(24'($urandom), 10'd512);
    idle(525);
    grant(24'($urandom), 10'd1023);
    idle(525);

    // Back-to-back with grant held and the request changing every cycle
    init_end_v = 1'b1;
    rd_en_v    = 1'b1;
    repeat (60) begin
      addr_v = 24'($urandom);
      len_v  = 10'($urandom_range(0, 6));
      cycle();
    end
    rd_en_v = 1'b0;
    idle(20);

    // Random bursts with random gaps
    repeat (10) begin
      grant(24'($urandom), 10'($urandom_range(0, 24)));
      idle($urandom_range(0, 40));
    end
    idle(40);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
